// File: rtl/mac_array.sv
// mac_array: CH-lane multiply-accumulate array computing NOUT dot products of K terms per job.
// Coefficients come two per synchronous-ROM word; results leave through a valid/ready port.
module mac_array #(
  parameter  int unsigned CH    = 4,
  parameter  int unsigned XW    = 9,
  parameter  int unsigned AW    = 7,
  parameter  int unsigned K     = 8,
  parameter  int unsigned NOUT  = 4,
  parameter  int unsigned ACCW  = 19,
  localparam int unsigned ADDRW = (NOUT * K / 2 > 1) ? $clog2(NOUT * K / 2) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sgn,
  output logic [ADDRW-1:0]    coef_addr,
  input  logic [2*AW-1:0]     coef_data,
  input  logic [CH*XW-1:0]    x_data,
  input  logic                x_valid,
  output logic                x_shift,
  output logic [CH*ACCW-1:0]  acc_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);
  localparam int unsigned KW = $clog2(K);
  localparam int unsigned NW = (NOUT > 1) ? $clog2(NOUT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NW-1:0]      n_q, n_d;
  logic [ADDRW-1:0]   addr_d;
  logic [AW-1:0]      lo_q, lo_d;
  logic               sgn_q, sgn_d;
  logic [ACCW-1:0]    acc_q [CH];
  logic [ACCW-1:0]    acc_d [CH];
  logic [ACCW-1:0]    sum   [CH];
  logic [CH*ACCW-1:0] acc_out_d;
  logic               out_valid_d, busy_d, done_d;
  logic               last_term, stall, consume;
  logic [AW-1:0]      a_sel;
  logic [ACCW-1:0]    a_ext;

  // Per-lane product-sum; even terms take the high half of the live ROM word, odd terms the saved low half.
  always_comb begin
    a_sel = k_q[0] ? lo_q : coef_data[2*AW-1:AW];
    a_ext = {{(ACCW-AW){sgn_q & a_sel[AW-1]}}, a_sel};
    for (int c = 0; c < CH; c++) begin
      sum[c] = acc_q[c] + a_ext * {{(ACCW-XW){sgn_q & x_data[c*XW+XW-1]}}, x_data[c*XW +: XW]};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    addr_d      = coef_addr;
    lo_d        = lo_q;
    sgn_d       = sgn_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out;
    out_valid_d = out_valid & ~out_ready;
    done_d      = 1'b0;
    consume     = 1'b0;
    last_term   = (k_q == KW'(K - 1));
    // Holding the final term keeps a fresh result from overwriting one the consumer has not taken.
    stall       = last_term & out_valid & ~out_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d   = sgn;
          k_d     = '0;
          n_d     = '0;
          addr_d  = '0;
          for (int c = 0; c < CH; c++) acc_d[c] = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = RUN;
      RUN: begin
        if (x_valid && !stall) begin
          consume = 1'b1;
          if (!k_q[0]) begin
            lo_d   = coef_data[AW-1:0];
            addr_d = coef_addr + ADDRW'(1);
          end
          if (last_term) begin
            for (int c = 0; c < CH; c++) begin
              acc_out_d[c*ACCW +: ACCW] = sum[c];
              acc_d[c]                  = '0;
            end
            out_valid_d = 1'b1;
            k_d         = '0;
            if (n_q == NW'(NOUT - 1)) state_d = DRAIN;
            else                      n_d     = n_q + NW'(1);
          end else begin
            acc_d = sum;
            k_d   = k_q + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (!out_valid_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign x_shift = consume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      coef_addr <= '0;
      lo_q      <= '0;
      sgn_q     <= 1'b0;
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      coef_addr <= addr_d;
      lo_q      <= lo_d;
      sgn_q     <= sgn_d;
      acc_q     <= acc_d;
      acc_out   <= acc_out_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: randomized self-checking bench for mac_array against an arithmetic dot-product model.
module tb_mac_array;
  localparam int unsigned CH    = 4;
  localparam int unsigned XW    = 9;
  localparam int unsigned AW    = 7;
  localparam int unsigned K     = 8;
  localparam int unsigned NOUT  = 4;
  localparam int unsigned ACCW  = 19;
  localparam int unsigned ADDRW = (NOUT * K / 2 > 1) ? $clog2(NOUT * K / 2) : 1;
  localparam int unsigned NT    = NOUT * K;
  localparam int unsigned NWORD = 1 << ADDRW;

  logic                clk, rst, start, sgn, x_valid, x_shift;
  logic                out_valid, out_ready, busy, done;
  logic [ADDRW-1:0]    coef_addr;
  logic [2*AW-1:0]     coef_data;
  logic [CH*XW-1:0]    x_data;
  logic [CH*ACCW-1:0]  acc_out;

  logic [2*AW-1:0]     rom [NWORD];
  logic [CH*XW-1:0]    xs  [NT];
  logic [CH*ACCW-1:0]  res_q [$];
  int                  n_checks = 0;
  int                  n_fail   = 0;

  mac_array #(.CH(CH), .XW(XW), .AW(AW), .K(K), .NOUT(NOUT), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .x_data(x_data), .x_valid(x_valid), .x_shift(x_shift),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous coefficient ROM.
  always @(posedge clk) coef_data <= rom[coef_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane(input logic [CH*ACCW-1:0] v, input int c);
    return longint'(v[c*ACCW +: ACCW]);
  endfunction

  // Dot product of output n, lane c straight from the ROM/X tables, reduced modulo 2^ACCW.
  function automatic longint model(input int n, input int c, input bit s);
    longint acc = 0;
    for (int k = 0; k < K; k++) begin
      logic [2*AW-1:0] w  = rom[(n*K + k) / 2];
      logic [AW-1:0]   a  = (k % 2 == 0) ? w[2*AW-1:AW] : w[AW-1:0];
      logic [XW-1:0]   x  = xs[n*K + k][c*XW +: XW];
      longint          av = longint'(a);
      longint          xv = longint'(x);
      if (s && a[AW-1]) av -= longint'(1) << AW;
      if (s && x[XW-1]) xv -= longint'(1) << XW;
      acc += av * xv;
    end
    return acc & ((longint'(1) << ACCW) - 1);
  endfunction

  task automatic fill_const(input logic [2*AW-1:0] w, input logic [XW-1:0] x);
    for (int i = 0; i < NWORD; i++) rom[i] = w;
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < CH; c++) xs[t][c*XW +: XW] = x;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NWORD; i++) rom[i] = (2*AW)'($urandom);
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < CH; c++) xs[t][c*XW +: XW] = XW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  longint'(coef_addr), 0);
    check({tag, "_acc"},   longint'(acc_out),   0);
    check({tag, "_oval"},  longint'(out_valid), 0);
    check({tag, "_busy"},  longint'(busy),      0);
    check({tag, "_done"},  longint'(done),      0);
    check({tag, "_shift"}, longint'(x_shift),   0);
  endtask

  // One job, cycle 0 = the cycle whose closing edge samples start. A second start is pulsed at cycle 5.
  task automatic run_job(input bit s, input bit gaps, input bit rdy_rand, input int stall_len,
                         input bit timing, input int abort_at);
    int cyc = 0, idx = 0, shifts = 0, dones = 0, done_cyc = -1, last_acc = -1, nres = 0;
    bit fin = 1'b0;
    res_q.delete();
    sgn = s;
    while (!fin) begin
      start     = (cyc == 0) || (cyc == 5);
      x_valid   = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
      out_ready = rdy_rand ? ($urandom_range(9, 0) < 7)
                           : !(stall_len > 0 && cyc >= K + 2 && cyc < K + 2 + stall_len);
      x_data    = (idx < NT) ? xs[idx] : '0;
      #1;
      if (timing && cyc == 1) check("busy_fetch", longint'(busy), 1);
      if (stall_len > 0 && cyc == K + 1 + stall_len) begin
        check("stall_shifts", shifts, 2*K - 1);
        check("stall_xshift", longint'(x_shift), 0);
      end
      if (x_shift) begin
        idx++;
        shifts++;
      end
      if (out_valid && out_ready) begin
        res_q.push_back(acc_out);
        if (timing) check("res_cycle", cyc, K + 2 + nres*K);
        nres++;
        last_acc = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        if (timing) check("done_cycle", cyc, NT + 3);
        check("busy_at_done", longint'(busy), 0);
      end
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        fin = 1'b1;
      end else if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        fin = 1'b1;
      end else if (cyc >= 3000) begin
        check("timeout_done", dones, 1);
        fin = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      cyc++;
    end
    start = 1'b0;
    if (abort_at < 0) begin
      check("n_results", res_q.size(), NOUT);
      check("n_shifts", shifts, NT);
      check("n_done", dones, 1);
      check("done_after_accept", done_cyc, last_acc + 1);
      for (int n = 0; n < res_q.size() && n < NOUT; n++)
        for (int c = 0; c < CH; c++)
          check("result", lane(res_q[n], c), model(n, c, s));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sgn = 1'b0; x_valid = 1'b0; out_ready = 1'b1; x_data = '0;
    fill_const('0, '0);
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // All-ones unsigned job with exact timing.
    fill_const({7'd1, 7'd1}, 9'd1);
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int n = 0; n < res_q.size(); n++)
      for (int c = 0; c < CH; c++) check("ones", lane(res_q[n], c), 8);

    // Signed and unsigned readings of the same all-ones bit patterns.
    fill_const({7'h7F, 7'h7F}, 9'h1FE);
    run_job(1'b1, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int c = 0; c < CH; c++) if (res_q.size() > 0) check("signed_corner", lane(res_q[0], c), 16);
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int c = 0; c < CH; c++) if (res_q.size() > 0) check("unsigned_corner", lane(res_q[0], c), 518160);

    // Coefficient ordering within and across ROM words.
    fill_rand();
    rom[0] = {7'd3, 7'd5};
    rom[1] = {7'd2, 7'd4};
    for (int t = 0; t < K; t++)
      for (int c = 0; c < CH; c++) xs[t][c*XW +: XW] = (t < 4) ? XW'(c + 1) : '0;
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int c = 0; c < CH; c++) if (res_q.size() > 0) check("ordering", lane(res_q[0], c), 14*(c + 1));

    // Random data: gap-free, then with x_valid gaps and random backpressure.
    for (int r = 0; r < 4; r++) begin
      bit s = bit'($urandom_range(1, 0));
      fill_rand();
      run_job(s, 1'b0, 1'b0, 0, 1'b1, -1);
      run_job(s, 1'b1, 1'b0, 0, 1'b0, -1);
      run_job(s, 1'b1, 1'b1, 0, 1'b0, -1);
    end

    // Consumer holds off for 20 cycles from the first result.
    fill_rand();
    run_job(1'b1, 1'b0, 1'b0, 20, 1'b0, -1);

    // Abort mid-RUN, then a fresh all-ones job.
    fill_const({7'd1, 7'd1}, 9'd1);
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b0, 15);
    @(negedge clk);
    run_job(1'b0, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int n = 0; n < res_q.size(); n++)
      for (int c = 0; c < CH; c++) check("ones_after_reset", lane(res_q[n], c), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
